// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: reads the PC, fetches from instruction memory,
// and hands each instruction to decode. Optional MEMRD timeout: FETCH_SEQ_TIMEOUT_EN.
module fetch_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        re_PC,
  output logic        wr_PC,
  output logic        PCinc,
  output logic [17:0] PCin,
  input  logic [17:0] PCout,
  output logic        mem_rd,
  output logic [17:0] mem_addr,
  input  logic        mem_ack,
  input  logic [17:0] mem_data,
  output logic [17:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_req,
  input  logic [17:0] br_target,
  output logic        busy,
`ifdef FETCH_SEQ_TIMEOUT_EN
  output logic        fetch_err,
`endif
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READPC = 3'd1;
  localparam logic [2:0] WAITPC = 3'd2;
  localparam logic [2:0] MEMRD  = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] INC    = 3'd5;
  localparam logic [2:0] BRANCH = 3'd6;

  logic [2:0]  state_q, state_d;
  logic        pend_q;
  logic [17:0] tgt_q;
  logic [17:0] addr_q;
  logic [17:0] instr_q;
  logic        br_pend;
  logic        tmo;

  // A request arriving this cycle counts as pending for this cycle's decision.
  assign br_pend = pend_q | br_req;

`ifdef FETCH_SEQ_TIMEOUT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt_q <= 8'd0;
    else if (state_q == MEMRD) cnt_q <= cnt_q + 8'd1;
    else                      cnt_q <= 8'd0;
  end

  // 255 MEMRD cycles have elapsed without an acknowledge.
  assign tmo       = (state_q == MEMRD) && (cnt_q == 8'hFF);
  assign fetch_err = tmo;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fetch_en) state_d = READPC;
      READPC: state_d = WAITPC;
      WAITPC: state_d = br_pend ? BRANCH : MEMRD;
      MEMRD: begin
        if (tmo)          state_d = br_pend ? BRANCH : READPC;
        else if (mem_ack) state_d = br_pend ? BRANCH : HOLD;
      end
      // Handshake: a transfer happens on any edge where instr_valid & instr_ready;
      // instr_valid never drops before that except when a redirect discards it.
      HOLD: begin
        if (br_pend)          state_d = BRANCH;
        else if (instr_ready) state_d = INC;
      end
      INC: begin
        if (br_pend)        state_d = BRANCH;
        else if (fetch_en)  state_d = READPC;
        else                state_d = IDLE;
      end
      BRANCH:  state_d = br_req ? BRANCH : READPC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      tgt_q   <= 18'd0;
      addr_q  <= 18'd0;
      instr_q <= 18'd0;
    end else begin
      state_q <= state_d;
      if (br_req) begin
        pend_q <= 1'b1;
        tgt_q  <= br_target;
      end else if (state_q == BRANCH) begin
        pend_q <= 1'b0;
      end
      if (state_q == WAITPC) addr_q <= PCout;
      if (state_q == MEMRD && mem_ack && !br_pend && !tmo) instr_q <= mem_data;
    end
  end

  assign re_PC       = (state_q == READPC);
  assign wr_PC       = (state_q == BRANCH);
  assign PCinc       = (state_q == INC);
  assign PCin        = tgt_q;
  assign mem_rd      = (state_q == MEMRD) && !tmo;
  assign mem_addr    = addr_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == HOLD);
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: reset, fetch latency, HOLD stall, redirects,
// async reset mid-read and, with FETCH_SEQ_TIMEOUT_EN, the MEMRD timeout.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic        re_PC, wr_PC, PCinc;
  logic [17:0] PCin;
  logic [17:0] PCout = 18'd0;
  logic        mem_rd;
  logic [17:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [17:0] mem_data = 18'd0;
  logic [17:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        br_req = 1'b0;
  logic [17:0] br_target = 18'd0;
  logic        busy;
  logic [2:0]  state_dbg;
`ifdef FETCH_SEQ_TIMEOUT_EN
  logic        fetch_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;
  logic [17:0] exp_q[$];

  fetch_seq dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .re_PC(re_PC), .wr_PC(wr_PC), .PCinc(PCinc),
    .PCin(PCin), .PCout(PCout),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_req(br_req), .br_target(br_target), .busy(busy),
`ifdef FETCH_SEQ_TIMEOUT_EN
    .fetch_err(fetch_err),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every decode transfer must match the next queued instruction
  always @(posedge clk) begin
    if (rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) check("xfer_spurious", exp_q.size(), 1);
      else                   check("xfer_data", instr, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst && !done) check("pc_onehot", ($countones({re_PC, wr_PC, PCinc}) <= 1), 1);
  end

  initial begin
    step();
    step();
    check("rst_state", state_dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_pcctl", {re_PC, wr_PC, PCinc}, 0);
    check("rst_pcin", PCin, 0);
    check("rst_mem", {mem_rd, mem_addr}, 0);
    check("rst_instr", {instr_valid, instr}, 0);

    // first fetch after reset release
    PCout = 18'd3; fetch_en = 1'b1; rst = 1'b1;
    step();
    check("c1_re_pc", re_PC, 1);
    step();
    check("c2_re_pc", re_PC, 0);
    check("c2_mem_rd", mem_rd, 0);
    step();
    check("c3_mem_rd", mem_rd, 1);
    check("c3_mem_addr", mem_addr, 18'd3);
    mem_ack = 1'b1; mem_data = 18'h1ABCD; exp_q.push_back(18'h1ABCD);
    step();
    mem_ack = 1'b0;
    check("c4_valid", instr_valid, 1);
    check("c4_instr", instr, 18'h1ABCD);

    // decode stalls for 10 cycles
    for (int i = 0; i < 9; i++) begin
      step();
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr, 18'h1ABCD);
      check("stall_pcinc", PCinc, 0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("inc_pcinc", PCinc, 1);
    check("inc_valid", instr_valid, 0);
    PCout = 18'd4;
    step();
    check("inc_once", PCinc, 0);
    check("loop_re_pc", re_PC, 1);

    // redirect during MEMRD, then a re-redirect in BRANCH
    step();
    step();
    check("br_mem_addr", mem_addr, 18'd4);
    instr_ready = 1'b1;
    br_req = 1'b1; br_target = 18'h00100; mem_ack = 1'b1; mem_data = 18'h02222;
    step();
    mem_ack = 1'b0;
    check("br_wr_pc", wr_PC, 1);
    check("br_pcin", PCin, 18'h00100);
    check("br_no_valid", instr_valid, 0);
    br_target = 18'h00180;
    step();
    br_req = 1'b0;
    check("br2_wr_pc", wr_PC, 1);
    check("br2_pcin", PCin, 18'h00180);
    step();
    instr_ready = 1'b0;
    check("br_re_pc", re_PC, 1);
    check("br_pcin_hold", PCin, 18'h00180);

    // redirect and transfer in the same HOLD cycle
    PCout = 18'h00180;
    step();
    step();
    check("hb_mem_addr", mem_addr, 18'h00180);
    mem_ack = 1'b1; mem_data = 18'h03333; exp_q.push_back(18'h03333);
    step();
    mem_ack = 1'b0;
    check("hb_instr", instr, 18'h03333);
    br_req = 1'b1; br_target = 18'h00200; instr_ready = 1'b1;
    step();
    br_req = 1'b0; instr_ready = 1'b0;
    check("hb_wr_pc", wr_PC, 1);
    check("hb_no_pcinc", PCinc, 0);
    check("hb_pcin", PCin, 18'h00200);
    check("hb_valid_drop", instr_valid, 0);
    step();
    check("hb_re_pc", re_PC, 1);

    // zero-wait loop; ack held outside MEMRD must be ignored
    PCout = 18'd5; mem_ack = 1'b1; mem_data = 18'h0AAAA; instr_ready = 1'b1;
    exp_q.push_back(18'h0AAAA);
    step();
    check("zw_waitpc", {re_PC, mem_rd, instr_valid}, 0);
    step();
    check("zw_mem_rd", mem_rd, 1);
    check("zw_mem_addr", mem_addr, 18'd5);
    step();
    check("zw_valid", instr_valid, 1);
    check("zw_instr", instr, 18'h0AAAA);
    fetch_en = 1'b0;
    step();
    mem_ack = 1'b0;
    check("zw_pcinc", PCinc, 1);
    step();
    check("zw_idle", busy, 0);

    // asynchronous reset mid-read with a late acknowledge
    fetch_en = 1'b1; PCout = 18'd7; instr_ready = 1'b0;
    step();
    step();
    step();
    check("ar_mem_rd", mem_rd, 1);
    #2 rst = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_mem", {mem_rd, mem_addr}, 0);
    check("ar_instr", {instr_valid, instr}, 0);
    check("ar_pc", {re_PC, wr_PC, PCinc, PCin}, 0);
    step();
    rst = 1'b1; mem_ack = 1'b1; mem_data = 18'h3FFFF;
    step();
    mem_ack = 1'b0;
    check("ar_restart_re_pc", re_PC, 1);
    check("ar_late_ack", {mem_rd, instr_valid}, 0);
    step();
    step();
    check("ar_mem_addr", mem_addr, 18'd7);
    mem_ack = 1'b1; mem_data = 18'h12345; exp_q.push_back(18'h12345); instr_ready = 1'b1;
    step();
    mem_ack = 1'b0; fetch_en = 1'b0;
    check("ar_instr2", instr, 18'h12345);
    step();
    instr_ready = 1'b0;
    check("ar_pcinc", PCinc, 1);
    step();
    check("ar_idle", busy, 0);

`ifdef FETCH_SEQ_TIMEOUT_EN
    // memory never answers
    fetch_en = 1'b1; PCout = 18'd9;
    step();
    step();
    step();
    check("to_mem_rd0", mem_rd, 1);
    for (int i = 0; i < 254; i++) step();
    check("to_err_early", fetch_err, 0);
    check("to_mem_rd254", mem_rd, 1);
    step();
    check("to_err", fetch_err, 1);
    check("to_mem_rd_drop", mem_rd, 0);
    fetch_en = 1'b0;
    step();
    check("to_err_pulse", fetch_err, 0);
    check("to_re_pc", re_PC, 1);
    step();
`endif

    done = 1'b1;
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
